// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Owns the fetch PC and drives the instruction-memory request/ready handshake.
// It takes stall, flush and branch-redirect controls from the hazard unit.
// A one-entry hold buffer keeps a word that memory returned while the pipe was stalled.
// A drain state lets a redirect wait out a request that memory has not yet answered.
// Optional feature macro: FETCH_PERF_CNT_EN enables the stall and bubble counters.
// With the macro undefined, both counter outputs are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        branch_sig,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic        validD,
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_BUF   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      IFID_HOLD   = 2'd0,
      IFID_BUBBLE = 2'd1,
      IFID_WORD   = 2'd2,
      IFID_BUF    = 2'd3
   } ifid_op_t;

   state_t      state, state_n;
   ifid_op_t    ifid_op;
   logic [31:0] pc_f, pc_n;
   logic [31:0] addr_f, addr_n;
   logic [31:0] hold_buf, buf_n;
   logic [31:0] addr_plus4;
   logic        stl;
   logic        hold_stl;

   // A flush overrides a stall, so the pipe only really holds when stalled and not flushed.
   assign stl        = stallF | stallD;
   assign hold_stl   = stl & ~flushD;
   assign addr_plus4 = addr_f + 32'd4;

   // The bus address is the registered fetch address.
   // No request is made while the buffer is full or reset is asserted.
   assign imem_addr = addr_f;
   assign imem_req  = reset & (state != S_BUF);

   // Fetch state, PC, bus address and hold buffer registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_FETCH;
         pc_f     <= RESET_PC;
         addr_f   <= RESET_PC;
         hold_buf <= 32'd0;
      end else begin
         state    <= state_n;
         pc_f     <= pc_n;
         addr_f   <= addr_n;
         hold_buf <= buf_n;
      end
   end

   // Next-state logic and the choice of what loads into IF/ID.
   // A redirect beats a flush, a flush beats a stall, and a stall beats a normal load.
   always_comb begin
      state_n = state;
      pc_n    = pc_f;
      addr_n  = addr_f;
      buf_n   = hold_buf;
      ifid_op = IFID_HOLD;
      if (branch_sig) begin
         ifid_op = IFID_BUBBLE;
         pc_n    = branch_target;
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  addr_n = branch_target;
               end else begin
                  state_n = S_DRAIN;
               end
            end
            S_BUF: begin
               addr_n  = branch_target;
               state_n = S_FETCH;
            end
            S_DRAIN: begin
               if (imem_ready) begin
                  addr_n  = branch_target;
                  state_n = S_FETCH;
               end
            end
            default: begin
               state_n = S_FETCH;
            end
         endcase
      end else begin
         case (state)
            S_FETCH: begin
               if (!imem_ready) begin
                  if (!hold_stl) begin
                     ifid_op = IFID_BUBBLE;
                  end
               end else begin
                  addr_n = addr_plus4;
                  pc_n   = addr_plus4;
                  if (!hold_stl) begin
                     ifid_op = flushD ? IFID_BUBBLE : IFID_WORD;
                  end else begin
                     buf_n   = imem_rdata;
                     state_n = S_BUF;
                  end
               end
            end
            S_BUF: begin
               if (!hold_stl) begin
                  ifid_op = flushD ? IFID_BUBBLE : IFID_BUF;
                  state_n = S_FETCH;
               end
            end
            S_DRAIN: begin
               if (!hold_stl) begin
                  ifid_op = IFID_BUBBLE;
               end
               if (imem_ready) begin
                  addr_n  = pc_f;
                  state_n = S_FETCH;
               end
            end
            default: begin
               state_n = S_FETCH;
            end
         endcase
      end
   end

   // IF/ID pipeline register, which loads a fetched word, the buffered word, a bubble, or holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instrD <= NOP_INSN;
         pcD    <= 32'd0;
         validD <= 1'b0;
      end else begin
         case (ifid_op)
            IFID_BUBBLE: begin
               instrD <= NOP_INSN;
               pcD    <= 32'd0;
               validD <= 1'b0;
            end
            IFID_WORD: begin
               instrD <= imem_rdata;
               pcD    <= addr_f;
               validD <= 1'b1;
            end
            IFID_BUF: begin
               instrD <= hold_buf;
               pcD    <= addr_f - 32'd4;
               validD <= 1'b1;
            end
            default: begin
               instrD <= instrD;
               pcD    <= pcD;
               validD <= validD;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] bubble_q;

   // Free-running wrap-around counters for stalled cycles and bubbles loaded into IF/ID.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q  <= 32'd0;
         bubble_q <= 32'd0;
      end else begin
         if (stl) begin
            stall_q <= stall_q + 32'd1;
         end
         if (ifid_op == IFID_BUBBLE) begin
            bubble_q <= bubble_q + 32'd1;
         end
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// The memory returns (address ^ WORD_KEY) combinationally, so each word encodes the address it came from.
// Each directed cycle states what IF/ID must do next.
// Words accepted from memory are queued, then popped when IF/ID presents a new instruction.
module tb_fetch_stage;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] WORD_KEY = 32'hC0DE_0000;
   localparam int EV_BUB  = 0;
   localparam int EV_NEW  = 1;
   localparam int EV_HOLD = 2;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallF, stallD, flushD, branch_sig;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instrD, pcD;
   logic        validD;
   logic [31:0] stall_cnt, bubble_cnt;

   int          testsRun = 0;
   int          testsFailed = 0;
   exp_t        sbQueue[$];
   logic [31:0] lastInstr, lastPc;
   logic        lastValid;
   logic [31:0] expStall, expBub;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .branch_sig(branch_sig), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .instrD(instrD), .pcD(pcD), .validD(validD),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Memory model whose returned word identifies its address.
   assign imem_rdata = imem_addr ^ WORD_KEY;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic checkCounters();
`ifdef FETCH_PERF_CNT_EN
      checkOutput("stall_cnt", stall_cnt, expStall);
      checkOutput("bubble_cnt", bubble_cnt, expBub);
`else
      checkOutput("stall_cnt_off", stall_cnt, 32'd0);
      checkOutput("bubble_cnt_off", bubble_cnt, 32'd0);
`endif
   endtask

   task automatic clearExpect();
      lastInstr = NOP;
      lastPc    = 32'd0;
      lastValid = 1'b0;
      expStall  = 32'd0;
      expBub    = 32'd0;
   endtask

   task automatic resetCheck();
      checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_imem_addr", imem_addr, 32'd0);
      checkOutput("rst_instrD", instrD, NOP);
      checkOutput("rst_pcD", pcD, 32'd0);
      checkOutput("rst_validD", {31'd0, validD}, 32'd0);
      checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
      checkOutput("rst_bubble_cnt", bubble_cnt, 32'd0);
   endtask

   // One clock cycle, entered and left at a falling edge.
   // acc means the word on the bus at this edge will eventually reach IF/ID.
   // ev says what IF/ID must show after the edge.
   task automatic applyStimulus(input logic sf, input logic sd, input logic fl, input logic br,
                                input logic [31:0] tgt, input logic rdy,
                                input logic [31:0] expAddr, input logic expReq,
                                input logic acc, input int ev);
      exp_t e;
      stallF        = sf;
      stallD        = sd;
      flushD        = fl;
      branch_sig    = br;
      branch_target = tgt;
      imem_ready    = rdy;
      #1;
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, expReq});
      checkOutput("imem_addr", imem_addr, expAddr);
      if (acc) sbQueue.push_back({expAddr ^ WORD_KEY, expAddr});
      if (sf | sd) expStall++;
      if (ev == EV_BUB) expBub++;
      @(posedge clk);
      #1;
      if (ev == EV_NEW) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sb_underflow", 32'(sbQueue.size()), 32'd1);
         end else begin
            e = sbQueue.pop_front();
            lastInstr = e.instr;
            lastPc    = e.pc;
            lastValid = 1'b1;
         end
      end else if (ev == EV_BUB) begin
         lastInstr = NOP;
         lastPc    = 32'd0;
         lastValid = 1'b0;
      end
      checkOutput("instrD", instrD, lastInstr);
      checkOutput("pcD", pcD, lastPc);
      checkOutput("validD", {31'd0, validD}, {31'd0, lastValid});
      checkCounters();
      @(negedge clk);
   endtask

   // Directed scenario sequence.
   initial begin
      reset = 1'b0;
      stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; branch_sig = 1'b0;
      branch_target = 32'd0; imem_ready = 1'b1;
      clearExpect();
      repeat (2) @(negedge clk);
      resetCheck();
      reset = 1'b1;

      // Streaming, then memory wait at 0x8.
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h0, 1, 1, EV_NEW);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h4, 1, 1, EV_NEW);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 32'd0, 0, 32'h8, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h8, 1, 1, EV_NEW);
      // Stall with ready high: the word goes into the buffer and the request drops.
      applyStimulus(1, 1, 0, 0, 32'd0, 1, 32'hC, 1, 1, EV_HOLD);
      applyStimulus(1, 1, 0, 0, 32'd0, 1, 32'h10, 0, 0, EV_HOLD);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h10, 0, 0, EV_NEW);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h10, 1, 1, EV_NEW);
      // Redirect with ready high.
      applyStimulus(0, 0, 0, 1, 32'h100, 1, 32'h14, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h100, 1, 1, EV_NEW);
      applyStimulus(0, 0, 0, 1, 32'h40, 1, 32'h104, 1, 0, EV_BUB);
      // Redirect during a memory wait goes through drain.
      applyStimulus(0, 0, 0, 1, 32'h200, 0, 32'h40, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 0, 32'h40, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h40, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h200, 1, 1, EV_NEW);
      // Flush: bubble, but PC still advances.
      applyStimulus(0, 0, 1, 0, 32'd0, 1, 32'h204, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h208, 1, 1, EV_NEW);
      // PC wrap at the top of the address space.
      applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h20C, 1, 0, EV_BUB);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFFC, 1, 1, EV_NEW);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h0, 1, 1, EV_NEW);
      // Stall during a memory wait holds IF/ID.
      applyStimulus(1, 0, 0, 0, 32'd0, 0, 32'h4, 1, 0, EV_HOLD);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h4, 1, 1, EV_NEW);
      // Enter drain, then reset asynchronously in the middle of it.
      applyStimulus(0, 0, 0, 1, 32'h300, 0, 32'h8, 1, 0, EV_BUB);
      checkOutput("sb_before_reset", 32'(sbQueue.size()), 32'd0);
      reset = 1'b0;
      #1;
      resetCheck();
      clearExpect();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h0, 1, 1, EV_NEW);
      applyStimulus(0, 0, 0, 0, 32'd0, 1, 32'h4, 1, 1, EV_NEW);
      checkOutput("sb_left", 32'(sbQueue.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
